// File: rtl/mono_bitmap_reveal.sv
// mono_bitmap_reveal
// ------------------
// 1-bit-per-pixel bitmap renderer for title / end-screen text in the VGA
// object pipeline. Each set bitmap bit is drawn in FG_COLOR, scaled by
// 2^SCALE_SHIFT. A small state machine adds a frame-synchronised
// left-to-right wipe reveal and a blink mode. Edge-hit codes and a done
// flag are reported for screen sequencing.
//
// Ports:
//   clk             in  1   pixel clock
//   resetN          in  1   synchronous, active-low reset
//   offsetX         in  11  X offset from the object's top-left
//   offsetY         in  11  Y offset from the object's top-left
//   InsideRectangle in  1   current pixel is inside the object bracket
//   startOfFrame    in  1   one-cycle pulse per frame
//   start           in  1   one-cycle pulse: sample mode, (re)start effect
//   mode            in  2   0 static, 1 wipe, 2 blink, 3 wipe then blink
//   drawingRequest  out 1   pixel is to be drawn (registered)
//   RGBout          out 12  pixel colour (registered)
//   HitEdgeCode     out 4   {Left, Top, Right, Bottom} (registered)
//   done            out 1   whole bitmap eligible for display (registered)

module mono_bitmap_reveal #(
  parameter int                          WIDTH         = 64,
  parameter int                          HEIGHT        = 32,
  parameter int                          SCALE_SHIFT   = 0,
  parameter logic [WIDTH*HEIGHT-1:0]     BITMAP        = '0,
  parameter logic [11:0]                 FG_COLOR      = 12'hFFF,
  parameter logic [11:0]                 TRANSPARENT   = 12'h000,
  parameter int                          REVEAL_FRAMES = 2,
  parameter int                          BLINK_FRAMES  = 32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        startOfFrame,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        drawingRequest,
  output logic [11:0] RGBout,
  output logic [3:0]  HitEdgeCode,
  output logic        done
);

  localparam int XB   = $clog2(WIDTH);
  localparam int YB   = $clog2(HEIGHT);
  localparam int MAXF = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int CW   = (MAXF > 1) ? $clog2(MAXF) : 1;

  localparam logic [CW-1:0] REVEAL_LAST = CW'(REVEAL_FRAMES - 1);
  localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_FRAMES - 1);
  localparam logic [XB:0]   COL_LAST    = (XB+1)'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SHOWN  = 2'd2,
    ST_BLINK  = 2'd3
  } state_t;

  // Effect state
  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [XB:0]   reveal_col_q, reveal_col_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          done_q, done_d;

  // Pixel output registers
  logic [11:0]   rgb_q, rgb_d;
  logic          draw_q, draw_d;
  logic [3:0]    hit_q, hit_d;

  // ---------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------
  logic [10:0]      sx, sy;
  logic             in_map;
  logic [XB-1:0]    col;
  logic [YB-1:0]    row;
  logic [XB+YB-1:0] bit_idx;
  logic             pix_bit;
  logic             visible;
  logic             lit;

  assign sx     = offsetX >> SCALE_SHIFT;
  assign sy     = offsetY >> SCALE_SHIFT;
  assign in_map = InsideRectangle && (sx < 11'(WIDTH)) && (sy < 11'(HEIGHT));
  assign col    = sx[XB-1:0];
  assign row    = sy[YB-1:0];

  // Row 0 / column 0 live at the MSB. Because WIDTH*HEIGHT is a power of
  // two, (WIDTH*HEIGHT-1) - {row,col} is simply the bitwise complement.
  assign bit_idx = {row, col};
  assign pix_bit = BITMAP[~bit_idx];

  always_comb begin
    visible = 1'b0;
    case (state_q)
      ST_REVEAL: visible = ({1'b0, col} < reveal_col_q);
      ST_SHOWN:  visible = 1'b1;
      ST_BLINK:  visible = blink_on_q;
      default:   visible = 1'b0;
    endcase
  end

  assign lit = in_map && pix_bit && visible;

  always_comb begin
    rgb_d  = lit ? FG_COLOR : TRANSPARENT;
    draw_d = (rgb_d != TRANSPARENT);
    hit_d  = 4'b0000;
    if (in_map) begin
      // Top two bits of the source coordinate give the quarter region 0..3.
      hit_d[3] = (col[XB-1 -: 2] == 2'd0);
      hit_d[2] = (row[YB-1 -: 2] == 2'd0);
      hit_d[1] = (col[XB-1 -: 2] == 2'd3);
      hit_d[0] = (row[YB-1 -: 2] == 2'd3);
    end
  end

  // ---------------------------------------------------------------------
  // Effect state machine
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    reveal_col_d = reveal_col_q;
    frame_cnt_d  = frame_cnt_q;
    blink_on_d   = blink_on_q;

    if (start) begin
      // start wins over a coincident frame pulse; that pulse is dropped.
      mode_d       = mode;
      frame_cnt_d  = '0;
      reveal_col_d = '0;
      blink_on_d   = 1'b1;
      case (mode)
        2'd0:    state_d = ST_SHOWN;
        2'd2:    state_d = ST_BLINK;
        default: state_d = ST_REVEAL;
      endcase
    end else if (startOfFrame) begin
      case (state_q)
        ST_REVEAL: begin
          if (frame_cnt_q == REVEAL_LAST) begin
            frame_cnt_d  = '0;
            reveal_col_d = reveal_col_q + (XB+1)'(1);
            // Last column just revealed: leave the wipe on this same edge.
            if (reveal_col_q == COL_LAST) begin
              if (mode_q == 2'd3) begin
                state_d    = ST_BLINK;
                blink_on_d = 1'b1;
              end else begin
                state_d = ST_SHOWN;
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
        ST_BLINK: begin
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

    done_d = (state_d == ST_SHOWN) || (state_d == ST_BLINK);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'd0;
      reveal_col_q <= '0;
      frame_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
      done_q       <= 1'b0;
      rgb_q        <= TRANSPARENT;
      draw_q       <= 1'b0;
      hit_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      reveal_col_q <= reveal_col_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_on_q   <= blink_on_d;
      done_q       <= done_d;
      rgb_q        <= rgb_d;
      draw_q       <= draw_d;
      hit_q        <= hit_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = draw_q;
  assign HitEdgeCode    = hit_q;
  assign done           = done_q;

endmodule

// File: tb/tb_mono_bitmap_reveal.sv
// Scoreboard bench for mono_bitmap_reveal. The driver issues one pixel per
// clock, computes the expected response from a frame-count model of the
// effect and pushes it into a queue; the monitor pops and compares one entry
// per output cycle.

module tb_mono_bitmap_reveal;

  localparam int W         = 16;
  localparam int H         = 8;
  localparam int S         = 1;
  localparam int RF        = 2;
  localparam int BF        = 3;
  localparam int FRAME_LEN = 5;
  localparam logic [W*H-1:0] BMP = 128'hF00F_8001_A5A5_3C3C_0FF0_C003_9249_E7E7;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] TR = 12'h000;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, startOfFrame, start;
  logic [1:0]  mode;
  logic        drawingRequest;
  logic [11:0] RGBout;
  logic [3:0]  HitEdgeCode;
  logic        done;

  mono_bitmap_reveal #(
    .WIDTH(W), .HEIGHT(H), .SCALE_SHIFT(S), .BITMAP(BMP),
    .FG_COLOR(FG), .TRANSPARENT(TR),
    .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN),
    .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .startOfFrame(startOfFrame),
    .start(start), .mode(mode),
    .drawingRequest(drawingRequest), .RGBout(RGBout),
    .HitEdgeCode(HitEdgeCode), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        draw;
    logic [3:0]  hit;
    logic        done;
    int          x;
    int          y;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model: effect described only by mode and frames since start.
  bit         m_started = 0;
  logic [1:0] m_mode    = 2'd0;
  int         m_n       = 0;

  function automatic bit m_visible(input int sx);
    if (!m_started) return 1'b0;
    case (m_mode)
      2'd0: return 1'b1;
      2'd1: return (m_n >= W*RF) ? 1'b1 : (sx < m_n / RF);
      2'd2: return ((m_n / BF) % 2) == 0;
      default: begin
        if (m_n < W*RF) return sx < m_n / RF;
        return (((m_n - W*RF) / BF) % 2) == 0;
      end
    endcase
  endfunction

  function automatic bit m_done();
    if (!m_started) return 1'b0;
    return (m_mode == 2'd0) || (m_mode == 2'd2) || (m_n >= W*RF);
  endfunction

  // Drive one cycle (called just after a falling edge), push expectation.
  task automatic cyc(input bit rst_n, input bit st, input bit sf,
                     input logic [1:0] md, input int x, input int y, input bit ins);
    exp_t e;
    int sx, sy, rx, ry;
    bit inmap, bitv, lit;
    logic [W*H-1:0] bm;
    resetN          = rst_n;
    start           = st;
    startOfFrame    = sf;
    mode            = md;
    offsetX         = 11'(x);
    offsetY         = 11'(y);
    InsideRectangle = ins;

    bm    = BMP;
    sx    = x >> S;
    sy    = y >> S;
    inmap = ins && (sx < W) && (sy < H);
    bitv  = 1'b0;
    if (inmap) bitv = bm[W*H-1 - (sy*W + sx)];
    e.x = x;
    e.y = y;
    if (!rst_n) begin
      e.rgb  = TR;
      e.draw = 1'b0;
      e.hit  = 4'b0000;
    end else begin
      lit    = inmap && bitv && m_visible(sx);
      e.rgb  = lit ? FG : TR;
      e.draw = (e.rgb != TR);
      e.hit  = 4'b0000;
      if (inmap) begin
        rx = sx / (W/4);
        ry = sy / (H/4);
        e.hit = {rx == 0, ry == 0, rx == 3, ry == 3};
      end
    end

    if (!rst_n) begin
      m_started = 0;
      m_n       = 0;
    end else if (st) begin
      m_started = 1;
      m_mode    = md;
      m_n       = 0;
    end else if (sf && m_started) begin
      m_n = m_n + 1;
    end
    e.done = rst_n ? m_done() : 1'b0;

    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_px(output int x, output int y, output bit ins);
    x   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, (W << S) + 5));
    y   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, (H << S) + 5));
    ins = ($urandom_range(0, 7) != 0);
  endtask

  task automatic run_frames(input int nf);
    int x, y;
    bit ins;
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        rand_px(x, y, ins);
        cyc(1'b1, 1'b0, c == 0, 2'($urandom), x, y, ins);
      end
    end
  endtask

  // Monitor: every output cycle for which a pixel was issued.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      txn++;
      checks += 4;
      if (RGBout !== mon_e.rgb) begin
        errors++;
        $display("FAIL rgb txn=%0d x=%0d y=%0d got=%h exp=%h", txn, mon_e.x, mon_e.y, RGBout, mon_e.rgb);
      end
      if (drawingRequest !== mon_e.draw) begin
        errors++;
        $display("FAIL draw txn=%0d x=%0d y=%0d got=%b exp=%b", txn, mon_e.x, mon_e.y, drawingRequest, mon_e.draw);
      end
      if (HitEdgeCode !== mon_e.hit) begin
        errors++;
        $display("FAIL hit txn=%0d x=%0d y=%0d got=%b exp=%b", txn, mon_e.x, mon_e.y, HitEdgeCode, mon_e.hit);
      end
      if (done !== mon_e.done) begin
        errors++;
        $display("FAIL done txn=%0d got=%b exp=%b", txn, done, mon_e.done);
      end
      $display("txn %0d x=%0d y=%0d rgb=%h draw=%b hit=%b done=%b", txn, mon_e.x, mon_e.y,
               RGBout, drawingRequest, HitEdgeCode, done);
    end
  end

  initial begin
    int x, y;
    bit ins;
    resetN = 1'b0; start = 1'b0; startOfFrame = 1'b0; mode = 2'd0;
    offsetX = '0; offsetY = '0; InsideRectangle = 1'b0;
    @(negedge clk);

    // Reset, then idle with frame pulses: nothing drawn, done low.
    for (int i = 0; i < 3; i++) begin
      rand_px(x, y, ins);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, x, y, ins);
    end
    run_frames(3);

    // Static mode: directed pixels, scaling and edge codes.
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd2, 8, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd3, 2, 2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 3, 3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 128, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 31, 15, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 10, 5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 0, 16, 1'b1);
    run_frames(6);

    // Wipe: column 1 lit / column 2 dark after 4 frames, then to completion.
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 0, 1'b1);
    run_frames(4);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 2, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 4, 6, 1'b1);
    run_frames(W*RF - 2);
    for (int i = 0; i < W; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 2*i, 0, 1'b1);

    // Wipe then blink, started together with a frame pulse.
    cyc(1'b1, 1'b1, 1'b1, 2'd3, 0, 0, 1'b1);
    run_frames(W*RF + 5*BF);

    // Restart from blink with start+frame pulse.
    cyc(1'b1, 1'b1, 1'b1, 2'd3, 0, 0, 1'b1);
    run_frames(5);

    // Plain blink.
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 0, 0, 1'b1);
    run_frames(4*BF + 1);

    // Restart mid-wipe, then reset mid-wipe and frames without start.
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 0, 0, 1'b1);
    run_frames(5);
    cyc(1'b1, 1'b1, 1'b1, 2'd1, 0, 0, 1'b1);
    run_frames(6);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 0, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 1'b1);
    run_frames(3);

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
